// File: rtl/xadc_drp_pkg.sv
// Shared definitions for the XADC DRP scheduler: scan address table, FSM encoding and constants.
// The scan order (TEMP, VCCINT, VCCAUX, VCCBRAM, AUX2, AUX3) fixes the slot index of every result.
package xadc_drp_pkg;

  localparam int          SCAN_LEN     = 6;
  localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    SCAN_ISSUE,
    SCAN_WAIT,
    HOST_ISSUE,
    HOST_WAIT
  } state_t;

  function automatic logic [6:0] scan_addr(input logic [2:0] slot);
    case (slot)
      3'd0:    scan_addr = 7'h00;
      3'd1:    scan_addr = 7'h01;
      3'd2:    scan_addr = 7'h02;
      3'd3:    scan_addr = 7'h06;
      3'd4:    scan_addr = 7'h12;
      default: scan_addr = 7'h13;
    endcase
  endfunction

endpackage

// File: rtl/xadc_drp_scheduler.sv
// DRP scheduler: six-register status scan per EOS plus one arbitrated host requester.
// Latency: DEN one cycle after EOS/host_req seen in IDLE; result L+1 cycles after DEN.
// Backpressure: host_req waits behind scans; one extra EOS is queued, further ones flag overrun.
module xadc_drp_scheduler
  import xadc_drp_pkg::*;
#(
  parameter int TIMEOUT = 63
) (
  input  logic        DCLK,
  input  logic        RESET,
  input  logic        EOS,
  output logic        DEN,
  output logic        DWE,
  output logic [6:0]  DADDR,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [6:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic [15:0] MEASURED_TEMP,
  output logic [15:0] MEASURED_VCCINT,
  output logic [15:0] MEASURED_VCCAUX,
  output logic [15:0] MEASURED_VCCBRAM,
  output logic [15:0] MEASURED_AUX2,
  output logic [15:0] MEASURED_AUX3,
  output logic        sample_valid,
  output logic        scan_busy,
  output logic        timeout_err,
  output logic        eos_overrun
);

  localparam logic [2:0] LAST_SLOT = 3'(SCAN_LEN - 1);

  state_t      state, state_nxt;
  logic [2:0]  slot;
  logic [5:0]  wait_cnt;
  logic [6:0]  wait_inc;
  logic        scan_pend;
  logic        host_rd;
  logic        in_wait;
  logic        drp_abort;
  logic        drp_done;
  logic [15:0] meas [SCAN_LEN];

  // The abort fires on the wait cycle whose increment would reach TIMEOUT; DRDY wins a tie.
  assign in_wait   = (state == SCAN_WAIT) || (state == HOST_WAIT);
  assign wait_inc  = {1'b0, wait_cnt} + 7'd1;
  assign drp_abort = in_wait && !DRDY && (wait_inc == 7'(TIMEOUT));
  assign drp_done  = in_wait && (DRDY || drp_abort);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (EOS || scan_pend) begin
          state_nxt = SCAN_ISSUE;
        end else if (host_req) begin
          state_nxt = HOST_ISSUE;
        end
      end
      SCAN_ISSUE: state_nxt = SCAN_WAIT;
      SCAN_WAIT: begin
        if (drp_done) begin
          state_nxt = (slot == LAST_SLOT) ? IDLE : SCAN_ISSUE;
        end
      end
      HOST_ISSUE: state_nxt = HOST_WAIT;
      HOST_WAIT: begin
        if (drp_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge DCLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge DCLK) begin
    if (RESET) begin
      slot         <= '0;
      wait_cnt     <= '0;
      scan_pend    <= 1'b0;
      host_rd      <= 1'b0;
      DEN          <= 1'b0;
      DWE          <= 1'b0;
      DADDR        <= '0;
      DI           <= '0;
      host_ack     <= 1'b0;
      host_rdata   <= '0;
      sample_valid <= 1'b0;
      scan_busy    <= 1'b0;
      timeout_err  <= 1'b0;
      eos_overrun  <= 1'b0;
      for (int i = 0; i < SCAN_LEN; i++) begin
        meas[i] <= '0;
      end
    end else begin
      DEN          <= (state_nxt == SCAN_ISSUE) || (state_nxt == HOST_ISSUE);
      DWE          <= 1'b0;
      host_ack     <= 1'b0;
      sample_valid <= 1'b0;
      scan_busy    <= (state_nxt == SCAN_ISSUE) || (state_nxt == SCAN_WAIT);

      if ((state == SCAN_ISSUE) || (state == HOST_ISSUE)) begin
        wait_cnt <= '0;
      end else if (in_wait && !DRDY) begin
        wait_cnt <= wait_inc[5:0];
      end

      // IDLE always consumes any pending scan; elsewhere EOS queues one deep.
      if (state == IDLE) begin
        scan_pend <= 1'b0;
      end else if (EOS) begin
        if (scan_pend) begin
          eos_overrun <= 1'b1;
        end else begin
          scan_pend <= 1'b1;
        end
      end

      if (state == IDLE && state_nxt == SCAN_ISSUE) begin
        slot  <= '0;
        DADDR <= scan_addr(3'd0);
        DI    <= '0;
      end

      if (state == IDLE && state_nxt == HOST_ISSUE) begin
        DADDR   <= host_addr;
        DI      <= host_wdata;
        DWE     <= host_we;
        host_rd <= !host_we;
      end

      if (state == SCAN_WAIT && drp_done) begin
        if (DRDY) begin
          meas[slot] <= DO;
        end
        if (drp_abort) begin
          timeout_err <= 1'b1;
        end
        if (slot == LAST_SLOT) begin
          sample_valid <= 1'b1;
        end else begin
          slot  <= slot + 3'd1;
          DADDR <= scan_addr(slot + 3'd1);
        end
      end

      if (state == HOST_WAIT && drp_done) begin
        host_ack <= 1'b1;
        if (drp_abort) begin
          timeout_err <= 1'b1;
          host_rdata  <= TIMEOUT_DATA;
        end else if (host_rd) begin
          host_rdata <= DO;
        end
      end
    end
  end

  assign MEASURED_TEMP    = meas[0];
  assign MEASURED_VCCINT  = meas[1];
  assign MEASURED_VCCAUX  = meas[2];
  assign MEASURED_VCCBRAM = meas[3];
  assign MEASURED_AUX2    = meas[4];
  assign MEASURED_AUX3    = meas[5];

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Bench for xadc_drp_scheduler: DRP memory model with programmable latency, event logs, per-scenario checks.
module tb_xadc_drp_scheduler;

  logic        DCLK, RESET, EOS, DEN, DWE, DRDY;
  logic [6:0]  DADDR;
  logic [15:0] DI, DO;
  logic        host_req, host_we, host_ack;
  logic [6:0]  host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic [15:0] MEASURED_TEMP, MEASURED_VCCINT, MEASURED_VCCAUX;
  logic [15:0] MEASURED_VCCBRAM, MEASURED_AUX2, MEASURED_AUX3;
  logic        sample_valid, scan_busy, timeout_err, eos_overrun;
  logic [15:0] meas_obs [6];

  typedef struct {
    int          cyc;
    logic [6:0]  addr;
    logic        we;
    logic [15:0] di;
    logic        busy;
  } den_ev_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          lat      = 3;
  bit          drop_en  = 0;
  logic [6:0]  drop_addr = '0;
  int          resp_cnt = 0;
  logic [15:0] resp_data = '0;
  int          te_cyc   = -1;
  logic [15:0] mem [128];
  logic [15:0] exp_meas [6];
  logic [15:0] exp_rdata = '0;
  int          scan_tab [6] = '{'h00, 'h01, 'h02, 'h06, 'h12, 'h13};
  den_ev_t     den_q [$];
  int          sv_q [$];
  logic        sv_busy_q [$];
  int          ack_q [$];
  logic [15:0] ack_data_q [$];

  xadc_drp_scheduler #(.TIMEOUT(63)) dut (
    .DCLK(DCLK), .RESET(RESET), .EOS(EOS), .DEN(DEN), .DWE(DWE), .DADDR(DADDR), .DI(DI),
    .DO(DO), .DRDY(DRDY), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .MEASURED_TEMP(MEASURED_TEMP), .MEASURED_VCCINT(MEASURED_VCCINT),
    .MEASURED_VCCAUX(MEASURED_VCCAUX), .MEASURED_VCCBRAM(MEASURED_VCCBRAM),
    .MEASURED_AUX2(MEASURED_AUX2), .MEASURED_AUX3(MEASURED_AUX3),
    .sample_valid(sample_valid), .scan_busy(scan_busy), .timeout_err(timeout_err),
    .eos_overrun(eos_overrun)
  );

  assign meas_obs[0] = MEASURED_TEMP;
  assign meas_obs[1] = MEASURED_VCCINT;
  assign meas_obs[2] = MEASURED_VCCAUX;
  assign meas_obs[3] = MEASURED_VCCBRAM;
  assign meas_obs[4] = MEASURED_AUX2;
  assign meas_obs[5] = MEASURED_AUX3;

  initial begin
    DCLK = 0;
    forever #5 DCLK = ~DCLK;
  end

  initial forever begin
    @(posedge DCLK);
    cyc++;
  end

  // DRP device model and event monitor, both sampling mid-cycle.
  initial begin
    den_ev_t ev;
    DRDY = 0;
    DO   = '0;
    forever begin
      @(negedge DCLK);
      DRDY = 0;
      DO   = 16'($urandom);
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          DRDY = 1;
          DO   = resp_data;
        end
      end
      if (DEN === 1'b1) begin
        ev.cyc = cyc; ev.addr = DADDR; ev.we = DWE; ev.di = DI; ev.busy = scan_busy;
        den_q.push_back(ev);
        if (DWE === 1'b1) mem[DADDR] = DI;
        if (!(drop_en && DADDR == drop_addr)) begin
          resp_cnt  = lat;
          resp_data = mem[DADDR];
        end
      end
      if (sample_valid === 1'b1) begin
        sv_q.push_back(cyc);
        sv_busy_q.push_back(scan_busy);
      end
      if (host_ack === 1'b1) begin
        ack_q.push_back(cyc);
        ack_data_q.push_back(host_rdata);
      end
      if (timeout_err === 1'b1 && te_cyc < 0) te_cyc = cyc;
    end
  end

  task automatic clear_logs();
    den_q.delete(); sv_q.delete(); sv_busy_q.delete(); ack_q.delete(); ack_data_q.delete();
  endtask

  task automatic test_reset();
    RESET = 1;
    repeat (3) @(posedge DCLK);
    @(negedge DCLK);
    n_checks++; if (DEN !== 1'b0) $display("FAIL reset_den: got %b want 0", DEN); else n_pass++;
    n_checks++; if (DWE !== 1'b0) $display("FAIL reset_dwe: got %b want 0", DWE); else n_pass++;
    n_checks++; if (DADDR !== 7'h0) $display("FAIL reset_daddr: got %h want 0", DADDR); else n_pass++;
    n_checks++; if (DI !== 16'h0) $display("FAIL reset_di: got %h want 0", DI); else n_pass++;
    n_checks++; if (host_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", host_ack); else n_pass++;
    n_checks++; if (host_rdata !== 16'h0) $display("FAIL reset_rdata: got %h want 0", host_rdata); else n_pass++;
    n_checks++; if (sample_valid !== 1'b0) $display("FAIL reset_sv: got %b want 0", sample_valid); else n_pass++;
    n_checks++; if (scan_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", scan_busy); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL reset_terr: got %b want 0", timeout_err); else n_pass++;
    n_checks++; if (eos_overrun !== 1'b0) $display("FAIL reset_ovr: got %b want 0", eos_overrun); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (meas_obs[k] !== 16'h0) $display("FAIL reset_meas%0d: got %h want 0", k, meas_obs[k]); else n_pass++;
    end
    RESET = 0;
    for (int k = 0; k < 6; k++) exp_meas[k] = '0;
    exp_rdata = '0;
  endtask

  task automatic test_scan(input int L, input bit rnd);
    int c, f;
    lat = L;
    if (rnd) for (int k = 0; k < 6; k++) mem[scan_tab[k]] = 16'($urandom);
    clear_logs();
    @(negedge DCLK); c = cyc; EOS = 1;
    @(negedge DCLK); EOS = 0;
    for (int i = 0; i < 400 && sv_q.size() < 1; i++) @(negedge DCLK);
    repeat (3) @(negedge DCLK);
    f = c + 1;
    n_checks++; if (sv_q.size() != 1) $display("FAIL scan_sv_count L=%0d: got %0d want 1", L, sv_q.size()); else n_pass++;
    n_checks++; if (den_q.size() != 6) $display("FAIL scan_den_count L=%0d: got %0d want 6", L, den_q.size()); else n_pass++;
    for (int k = 0; k < den_q.size() && k < 6; k++) begin
      n_checks++;
      if (den_q[k].addr !== 7'(scan_tab[k]) || den_q[k].we !== 1'b0 || den_q[k].cyc != f + k * (L + 1) || den_q[k].busy !== 1'b1)
        $display("FAIL scan_den%0d L=%0d: got addr=%h we=%b cyc=%0d busy=%b want addr=%h we=0 cyc=%0d busy=1",
                 k, L, den_q[k].addr, den_q[k].we, den_q[k].cyc, den_q[k].busy, scan_tab[k], f + k * (L + 1));
      else n_pass++;
    end
    if (sv_q.size() > 0) begin
      n_checks++;
      if (sv_q[0] != f + 6 * (L + 1) || sv_busy_q[0] !== 1'b0)
        $display("FAIL scan_sv_time L=%0d: got cyc=%0d busy=%b want cyc=%0d busy=0", L, sv_q[0], sv_busy_q[0], f + 6 * (L + 1));
      else n_pass++;
    end
    for (int k = 0; k < 6; k++) begin
      exp_meas[k] = mem[scan_tab[k]];
      n_checks++;
      if (meas_obs[k] !== exp_meas[k]) $display("FAIL scan_meas%0d L=%0d: got %h want %h", k, L, meas_obs[k], exp_meas[k]); else n_pass++;
    end
  endtask

  task automatic test_host(input int L, input logic [6:0] a, input logic we, input logic [15:0] wd);
    int c;
    bit got;
    logic [15:0] exp_d;
    lat = L;
    exp_d = we ? exp_rdata : mem[a];
    clear_logs();
    @(negedge DCLK); c = cyc;
    host_req = 1; host_addr = a; host_we = we; host_wdata = wd;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge DCLK);
      if (host_ack === 1'b1) got = 1;
    end
    host_req = 0;
    repeat (3) @(negedge DCLK);
    n_checks++; if (!got) $display("FAIL host_ack_seen a=%h we=%b: got none want 1", a, we); else n_pass++;
    n_checks++; if (den_q.size() != 1) $display("FAIL host_den_count a=%h: got %0d want 1", a, den_q.size()); else n_pass++;
    if (den_q.size() > 0) begin
      n_checks++;
      if (den_q[0].cyc != c + 1 || den_q[0].addr !== a || den_q[0].we !== we || (we && den_q[0].di !== wd))
        $display("FAIL host_den a=%h we=%b: got cyc=%0d addr=%h we=%b di=%h want cyc=%0d di=%h",
                 a, we, den_q[0].cyc, den_q[0].addr, den_q[0].we, den_q[0].di, c + 1, wd);
      else n_pass++;
    end
    if (ack_q.size() > 0) begin
      n_checks++;
      if (ack_q[0] != c + L + 2 || ack_data_q[0] !== exp_d)
        $display("FAIL host_ack a=%h we=%b: got cyc=%0d data=%h want cyc=%0d data=%h", a, we, ack_q[0], ack_data_q[0], c + L + 2, exp_d);
      else n_pass++;
    end
    exp_rdata = exp_d;
  endtask

  task automatic test_eos_and_host();
    int c;
    bit got;
    logic [6:0]  a;
    logic [15:0] exp_d;
    lat = 3;
    a = 7'h41;
    exp_d = mem[a];
    clear_logs();
    @(negedge DCLK); c = cyc;
    EOS = 1; host_req = 1; host_we = 0; host_addr = a; host_wdata = 16'($urandom);
    @(negedge DCLK); EOS = 0;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge DCLK);
      if (host_ack === 1'b1) got = 1;
    end
    host_req = 0;
    repeat (3) @(negedge DCLK);
    n_checks++; if (den_q.size() != 7) $display("FAIL mix_den_count: got %0d want 7", den_q.size()); else n_pass++;
    n_checks++; if (sv_q.size() != 1) $display("FAIL mix_sv_count: got %0d want 1", sv_q.size()); else n_pass++;
    if (den_q.size() == 7 && sv_q.size() == 1) begin
      n_checks++;
      if (den_q[0].addr !== 7'h00 || den_q[0].cyc != c + 1) $display("FAIL mix_scan_first: got addr=%h cyc=%0d want addr=00 cyc=%0d", den_q[0].addr, den_q[0].cyc, c + 1); else n_pass++;
      n_checks++;
      if (den_q[6].addr !== a || den_q[6].cyc != sv_q[0] + 1) $display("FAIL mix_host_den: got addr=%h cyc=%0d want addr=%h cyc=%0d", den_q[6].addr, den_q[6].cyc, a, sv_q[0] + 1); else n_pass++;
    end
    n_checks++;
    if (!got || ack_data_q.size() == 0 || ack_data_q[0] !== exp_d) $display("FAIL mix_host_data: got ack=%0d want data=%h", got, exp_d); else n_pass++;
    exp_rdata = exp_d;
    for (int k = 0; k < 6; k++) exp_meas[k] = mem[scan_tab[k]];
  endtask

  task automatic test_eos_pending(input int extra);
    lat = 3;
    clear_logs();
    @(negedge DCLK); EOS = 1;
    for (int i = 1; i < 90; i++) begin
      @(negedge DCLK);
      EOS = (extra >= 1 && i == 5) || (extra >= 2 && i == 10);
    end
    EOS = 0;
    n_checks++; if (sv_q.size() != 2) $display("FAIL pend%0d_sv_count: got %0d want 2", extra, sv_q.size()); else n_pass++;
    n_checks++; if (den_q.size() != 12) $display("FAIL pend%0d_den_count: got %0d want 12", extra, den_q.size()); else n_pass++;
    if (den_q.size() >= 7 && sv_q.size() >= 1) begin
      n_checks++;
      if (den_q[6].addr !== 7'h00 || den_q[6].cyc != sv_q[0] + 1)
        $display("FAIL pend%0d_restart: got addr=%h cyc=%0d want addr=00 cyc=%0d", extra, den_q[6].addr, den_q[6].cyc, sv_q[0] + 1);
      else n_pass++;
    end
    n_checks++;
    if (eos_overrun !== (extra >= 2)) $display("FAIL pend%0d_overrun: got %b want %b", extra, eos_overrun, extra >= 2); else n_pass++;
  endtask

  task automatic test_timeout();
    int c, d;
    bit got;
    logic [15:0] old;
    lat = 2;
    drop_en = 1; drop_addr = 7'h02;
    old = exp_meas[2];
    for (int k = 0; k < 6; k++) mem[scan_tab[k]] = 16'($urandom);
    mem[7'h02] = old ^ 16'h5A5A;
    clear_logs();
    @(negedge DCLK); c = cyc; EOS = 1;
    @(negedge DCLK); EOS = 0;
    for (int i = 0; i < 400 && sv_q.size() < 1; i++) @(negedge DCLK);
    repeat (3) @(negedge DCLK);
    n_checks++; if (den_q.size() != 6) $display("FAIL to_den_count: got %0d want 6", den_q.size()); else n_pass++;
    if (den_q.size() >= 4) begin
      d = den_q[2].cyc;
      n_checks++;
      if (den_q[3].addr !== 7'h06 || den_q[3].cyc != d + 64) $display("FAIL to_next_den: got addr=%h cyc=%0d want addr=06 cyc=%0d", den_q[3].addr, den_q[3].cyc, d + 64); else n_pass++;
      n_checks++;
      if (te_cyc != d + 64) $display("FAIL to_err_time: got %0d want %0d", te_cyc, d + 64); else n_pass++;
    end
    n_checks++;
    if (sv_q.size() == 0 || sv_q[0] != c + 1 + 5 * 3 + 64) $display("FAIL to_sv_time: got size=%0d want cyc=%0d", sv_q.size(), c + 80); else n_pass++;
    n_checks++; if (timeout_err !== 1'b1) $display("FAIL to_err: got %b want 1", timeout_err); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      if (k != 2) exp_meas[k] = mem[scan_tab[k]];
      n_checks++;
      if (meas_obs[k] !== exp_meas[k]) $display("FAIL to_meas%0d: got %h want %h", k, meas_obs[k], exp_meas[k]); else n_pass++;
    end
    clear_logs();
    @(negedge DCLK); c = cyc;
    host_req = 1; host_we = 0; host_addr = 7'h02; host_wdata = '0;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge DCLK);
      if (host_ack === 1'b1) got = 1;
    end
    host_req = 0;
    repeat (2) @(negedge DCLK);
    n_checks++;
    if (ack_q.size() == 0 || ack_q[0] != c + 1 + 64 || ack_data_q[0] !== 16'hFFFF)
      $display("FAIL to_host_abort: got acks=%0d want cyc=%0d data=ffff", ack_q.size(), c + 65);
    else n_pass++;
    exp_rdata = 16'hFFFF;
    drop_en = 0;
  endtask

  task automatic test_reset_mid();
    int n;
    lat = 3;
    clear_logs();
    @(negedge DCLK); EOS = 1;
    @(negedge DCLK); EOS = 0;
    for (int i = 0; i < 100 && den_q.size() < 4; i++) @(negedge DCLK);
    if (den_q.size() >= 4) while (cyc < den_q[3].cyc + 1) @(negedge DCLK);
    RESET = 1;
    @(negedge DCLK);
    n_checks++;
    if ({DEN, DWE, DADDR, DI, host_ack, host_rdata, MEASURED_TEMP, MEASURED_VCCINT, MEASURED_VCCAUX,
         MEASURED_VCCBRAM, MEASURED_AUX2, MEASURED_AUX3, sample_valid, scan_busy, timeout_err, eos_overrun} !== '0)
      $display("FAIL midreset_outputs: got den=%b addr=%h busy=%b terr=%b ovr=%b temp=%h want all zero",
               DEN, DADDR, scan_busy, timeout_err, eos_overrun, MEASURED_TEMP);
    else n_pass++;
    RESET = 0;
    te_cyc = -1;
    for (int k = 0; k < 6; k++) exp_meas[k] = '0;
    exp_rdata = '0;
    n = den_q.size();
    repeat (12) @(negedge DCLK);
    n_checks++; if (den_q.size() != n || sv_q.size() != 0) $display("FAIL midreset_quiet: got den=%0d sv=%0d want den=%0d sv=0", den_q.size(), sv_q.size(), n); else n_pass++;
    n_checks++; if (MEASURED_VCCBRAM !== 16'h0 || scan_busy !== 1'b0) $display("FAIL midreset_late_drdy: got %h busy=%b want 0", MEASURED_VCCBRAM, scan_busy); else n_pass++;
  endtask

  initial begin
    RESET = 1; EOS = 0; host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    for (int a = 0; a < 128; a++) mem[a] = {7'(a), 9'h0A5};
    test_reset();
    test_scan(3, 0);
    for (int r = 0; r < 3; r++) test_scan($urandom_range(1, 5), 1);
    test_host(3, 7'h41, 1'b0, 16'h0);
    test_host(3, 7'h41, 1'b1, 16'h1234);
    test_host(3, 7'h41, 1'b0, 16'h0);
    for (int r = 0; r < 6; r++) test_host($urandom_range(1, 5), 7'($urandom), 1'($urandom), 16'($urandom));
    test_eos_and_host();
    test_eos_pending(1);
    test_eos_pending(2);
    test_timeout();
    test_reset_mid();
    test_scan(3, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
